// File: rtl/tcb_infer_if.sv
// tcb_infer_if: host stream, network handshake and statistics signals of tcb_infer_ctrl
interface tcb_infer_if #(
  parameter int IMG_W = 968,
  parameter int CLS_W = 32,
  parameter int CNT_W = 16
);
  logic [IMG_W-1:0] in_img;
  logic [CLS_W-1:0] in_label;
  logic             in_valid;
  logic             in_ready;
  logic [IMG_W-1:0] net_img;
  logic             net_start;
  logic             net_done;
  logic [CLS_W-1:0] net_number;
  logic [CLS_W-1:0] out_pred;
  logic             out_correct;
  logic             out_err;
  logic             out_valid;
  logic             out_ready;
  logic             stat_clr;
  logic [CNT_W-1:0] stat_total;
  logic [CNT_W-1:0] stat_correct;
  logic             busy;
  modport slave (
    input  in_img, in_label, in_valid, net_done, net_number, out_ready, stat_clr,
    output in_ready, net_img, net_start, out_pred, out_correct, out_err, out_valid,
           stat_total, stat_correct, busy
  );
  modport master (
    output in_img, in_label, in_valid, net_done, net_number, out_ready, stat_clr,
    input  in_ready, net_img, net_start, out_pred, out_correct, out_err, out_valid,
           stat_total, stat_correct, busy
  );
endinterface

// File: rtl/tcb_infer_ctrl.sv
// tcb_infer_ctrl: image-in/result-out inference sequencer with accuracy counters; define TCB_WDOG_EN for the WAIT watchdog
module tcb_infer_ctrl #(
  parameter int IMG_W       = 968,
  parameter int CLS_W       = 32,
  parameter int NUM_CLASSES = 10,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 4096
) (
  input logic         clk,
  input logic         rst,
  tcb_infer_if.slave  io_bus
);
  typedef enum logic [1:0] {IDLE, START, WAIT, RESULT} state_t;
  state_t           r_state, w_next;
  logic [IMG_W-1:0] r_img;
  logic [CLS_W-1:0] r_label, r_pred, w_pred;
  logic             r_correct, r_err, w_correct, w_err, w_cap, w_to;
  logic [CNT_W-1:0] r_total, r_ncorrect;
`ifdef TCB_WDOG_EN
  localparam int WD_W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [WD_W-1:0] r_wd;
  always_ff @(posedge clk)
    r_wd <= (rst || r_state == START) ? '0 : r_wd + 1'b1;
  assign w_to = r_state == WAIT && !io_bus.net_done && r_wd == WD_W'(TIMEOUT - 1);
`else
  assign w_to = 1'b0;
`endif
  assign w_cap     = r_state == WAIT && (io_bus.net_done || w_to);
  assign w_pred    = io_bus.net_done ? io_bus.net_number : '1;
  assign w_correct = io_bus.net_done && io_bus.net_number == r_label && r_label < CLS_W'(NUM_CLASSES);
  assign w_err     = w_pred >= CLS_W'(NUM_CLASSES);
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && io_bus.in_valid) w_next = START;
    if (r_state == START) w_next = WAIT;
    if (w_cap) w_next = RESULT;
    if (r_state == RESULT && io_bus.out_ready) w_next = IDLE;
  end
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_img      <= '0;
      r_label    <= '0;
      r_pred     <= '0;
      r_correct  <= 1'b0;
      r_err      <= 1'b0;
      r_total    <= '0;
      r_ncorrect <= '0;
    end else begin
      if (r_state == IDLE && io_bus.in_valid) begin
        r_img   <= io_bus.in_img;
        r_label <= io_bus.in_label;
      end
      if (w_cap) begin
        r_pred    <= w_pred;
        r_correct <= w_correct;
        r_err     <= w_err;
      end
      if (io_bus.stat_clr) begin
        r_total    <= '0;
        r_ncorrect <= '0;
      end else if (w_cap) begin
        r_total    <= r_total + CNT_W'(~&r_total);
        r_ncorrect <= r_ncorrect + CNT_W'(w_correct && !(&r_ncorrect));
      end
    end
  end
  assign io_bus.in_ready     = r_state == IDLE;
  assign io_bus.net_start    = r_state == START;
  assign io_bus.out_valid    = r_state == RESULT;
  assign io_bus.busy         = r_state != IDLE;
  assign io_bus.net_img      = r_img;
  assign io_bus.out_pred     = r_pred;
  assign io_bus.out_correct  = r_correct;
  assign io_bus.out_err      = r_err;
  assign io_bus.stat_total   = r_total;
  assign io_bus.stat_correct = r_ncorrect;
endmodule

// File: tb/tb_tcb_infer_ctrl.sv
// tb_tcb_infer_ctrl: directed literal checks plus randomized traffic against a per-cycle behavioural model
module tb_tcb_infer_ctrl;
  localparam int IMG_W = 968, CLS_W = 32, NC = 10, CNT_W = 8, TO = 16;
  localparam int SAT = (1 << CNT_W) - 1;
  logic clk = 0, rst = 0, drv_clr = 0, clr_pulse = 0;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  tcb_infer_if #(.IMG_W(IMG_W), .CLS_W(CLS_W), .CNT_W(CNT_W)) bus ();
  tcb_infer_ctrl #(.IMG_W(IMG_W), .CLS_W(CLS_W), .NUM_CLASSES(NC), .CNT_W(CNT_W), .TIMEOUT(TO))
    dut (.clk(clk), .rst(rst), .io_bus(bus));
  assign bus.stat_clr = drv_clr | clr_pulse;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [IMG_W-1:0] rand_img();
    logic [IMG_W-1:0] v;
    for (int i = 0; i < IMG_W / 8; i++) v[i*8 +: 8] = 8'($urandom_range(0, 255));
    return v;
  endfunction

  function automatic logic [IMG_W-1:0] pat_a();
    logic [IMG_W-1:0] v;
    for (int i = 0; i < IMG_W / 8; i++) v[i*8 +: 8] = 8'(i) ^ 8'h5A;
    return v;
  endfunction

  // behavioural model: spec states as phases 0..3, stats as saturating ints
  int ph = 0, m_tot = 0, m_cnt = 0, m_wait = 0, cyc = 0, last_start = -1, min_gap = 1000, n_starts = 0;
  logic mv = 0, m_cor = 0, m_err = 0;
  logic [IMG_W-1:0] m_img = '0;
  logic [CLS_W-1:0] m_label = '0, m_pred = '0;

  always @(negedge clk) begin
    logic cap;
    logic [CLS_W-1:0] p;
    cyc++;
    if (mv) begin
      chk("in_ready", bus.in_ready, ph == 0);
      chk("net_start", bus.net_start, ph == 1);
      chk("out_valid", bus.out_valid, ph == 3);
      chk("busy", bus.busy, ph != 0);
      chk("net_img_eq", bus.net_img == m_img, 1);
      chk("out_pred", bus.out_pred, m_pred);
      chk("out_correct", bus.out_correct, m_cor);
      chk("out_err", bus.out_err, m_err);
      chk("stat_total", bus.stat_total, m_tot);
      chk("stat_correct", bus.stat_correct, m_cnt);
      if (bus.net_start) begin
        n_starts++;
        if (last_start >= 0 && cyc - last_start < min_gap) min_gap = cyc - last_start;
        last_start = cyc;
      end
    end
    cap = 0;
    p = '0;
    if (rst) begin
      ph = 0; m_img = '0; m_label = '0; m_pred = '0; m_cor = 0; m_err = 0;
      m_tot = 0; m_cnt = 0; mv = 1; last_start = -1;
    end else if (mv) begin
      if (ph == 0 && bus.in_valid) begin
        m_img = bus.in_img; m_label = bus.in_label; ph = 1;
      end else if (ph == 1) begin
        ph = 2; m_wait = 0;
      end else if (ph == 2) begin
        m_wait++;
        if (bus.net_done) begin cap = 1; p = bus.net_number; end
`ifdef TCB_WDOG_EN
        else if (m_wait == TO) begin cap = 1; p = '1; end
`endif
      end else if (ph == 3 && bus.out_ready) ph = 0;
      if (cap) begin
        m_pred = p;
        m_cor = (p == m_label) && (m_label < NC);
        m_err = p >= NC;
        ph = 3;
      end
      if (bus.stat_clr) begin m_tot = 0; m_cnt = 0; end
      else if (cap) begin
        m_tot = m_tot < SAT ? m_tot + 1 : SAT;
        if (m_cor) m_cnt = m_cnt < SAT ? m_cnt + 1 : SAT;
      end
    end
  end

  // network model: answers each start after a delay (0 = never), optional stray done pulses
  int net_fixed = 1, net_val = 0, net_delay = 1, stray_en = 0, clr_on_done = 0, cnt = 0;
  logic pend = 0;

  function automatic int rand_delay();
`ifdef TCB_WDOG_EN
    return $urandom_range(0, 9) == 0 ? 0 : int'($urandom_range(1, 20));
`else
    return $urandom_range(1, 8);
`endif
  endfunction

  function automatic logic [CLS_W-1:0] pick();
    int r = $urandom_range(0, 3);
    return r < 2 ? m_label : (r == 2 ? CLS_W'($urandom_range(0, 11)) : CLS_W'($urandom));
  endfunction

  always @(posedge clk) begin
    logic fired;
    #1;
    fired = 0;
    bus.net_done = 0;
    bus.net_number = CLS_W'($urandom);
    if (pend && cnt > 0) begin
      cnt--;
      if (cnt == 0) fired = 1;
    end
    if (fired) begin
      bus.net_done = 1;
      pend = 0;
      bus.net_number = net_fixed != 0 ? CLS_W'(net_val) : pick();
    end else if (!pend && stray_en != 0 && $urandom_range(0, 7) == 0) bus.net_done = 1;
    clr_pulse = fired && clr_on_done != 0;
    if (bus.net_start) begin
      pend = 1;
      cnt = net_fixed != 0 ? net_delay : rand_delay();
    end
  end

  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic run_img(input logic [CLS_W-1:0] lab, input logic [IMG_W-1:0] img, output int lat);
    bus.in_img = img; bus.in_label = lab; bus.in_valid = 1;
    for (int i = 0; i < 50 && !bus.in_ready; i++) tick();
    tick();
    bus.in_valid = 0;
    chk("start_after_accept", bus.net_start, 1);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin tick(); lat++; end
    chk("out_valid_seen", bus.out_valid, 1);
  endtask

  task automatic drain();
    bus.in_valid = 0;
    for (int i = 0; i < 100 && bus.busy; i++) tick();
    chk("drained", bus.busy, 0);
  endtask

  initial begin
    int lat, acc, s0;
    bus.in_valid = 0; bus.in_img = '0; bus.in_label = '0; bus.out_ready = 0;
    // 1: reset values, single correct image, 5-cycle network
    do_reset();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_net_start", bus.net_start, 0);
    chk("rst_out_pred", bus.out_pred, 0);
    chk("rst_total", bus.stat_total, 0);
    net_fixed = 1; net_val = 3; net_delay = 5;
    run_img(3, pat_a(), lat);
    chk("t1_latency", lat, 6);
    chk("t1_net_img", bus.net_img == pat_a(), 1);
    chk("t1_pred", bus.out_pred, 3);
    chk("t1_correct", bus.out_correct, 1);
    chk("t1_err", bus.out_err, 0);
    chk("t1_total", bus.stat_total, 1);
    chk("t1_ncorrect", bus.stat_correct, 1);
    bus.out_ready = 1; tick(); bus.out_ready = 0;
    chk("t1_back_idle", bus.in_ready, 1);
    // 2: result held under back-pressure
    do_reset();
    net_val = 2; net_delay = 3;
    run_img(7, rand_img(), lat);
    for (int i = 0; i < 10; i++) begin
      chk("t2_hold_valid", bus.out_valid, 1);
      chk("t2_hold_pred", bus.out_pred, 2);
      chk("t2_no_in_ready", bus.in_ready, 0);
      chk("t2_no_start", bus.net_start, 0);
      tick();
    end
    bus.out_ready = 1; tick(); bus.out_ready = 0;
    chk("t2_released", bus.out_valid, 0);
    chk("t2_total", bus.stat_total, 1);
    chk("t2_ncorrect", bus.stat_correct, 0);
    // 3: three back-to-back images, stray done pulses
    do_reset();
    net_fixed = 0; stray_en = 1; s0 = n_starts; acc = 0;
    bus.in_valid = 1; bus.out_ready = 1;
    for (int i = 0; i < 200 && acc < 3; i++) begin
      bus.in_img = rand_img(); bus.in_label = CLS_W'($urandom_range(0, 9));
      if (bus.in_ready) acc++;
      tick();
    end
    drain();
    for (int i = 0; i < 6; i++) tick();
    chk("t3_starts", n_starts - s0, 3);
    chk("t3_total", bus.stat_total, 3);
    stray_en = 0; net_fixed = 1;
    // 4: out-of-range label and prediction
    do_reset();
    bus.out_ready = 0; net_val = 12; net_delay = 2;
    run_img(12, rand_img(), lat);
    chk("t4_correct", bus.out_correct, 0);
    chk("t4_err", bus.out_err, 1);
    chk("t4_ncorrect", bus.stat_correct, 0);
    chk("t4_total", bus.stat_total, 1);
    bus.out_ready = 1; tick();
    // 5: saturation, then clear colliding with a capture
    do_reset();
    net_val = 4; net_delay = 1; acc = 0;
    bus.in_valid = 1; bus.in_label = 4;
    for (int i = 0; i < 3000 && acc < SAT + 2; i++) begin
      if (bus.in_ready) acc++;
      tick();
    end
    drain();
    chk("t5_total_sat", bus.stat_total, SAT);
    chk("t5_ncorrect_sat", bus.stat_correct, SAT);
    clr_on_done = 1;
    run_img(4, rand_img(), lat);
    chk("t5_clr_total", bus.stat_total, 0);
    chk("t5_clr_ncorrect", bus.stat_correct, 0);
    clr_on_done = 0;
    drain();
`ifdef TCB_WDOG_EN
    // 6: watchdog abort, done on the abort cycle, reset mid-WAIT
    do_reset();
    bus.out_ready = 0; net_delay = 0;
    run_img(5, rand_img(), lat);
    chk("t6_wd_latency", lat, TO + 1);
    chk("t6_wd_pred", bus.out_pred, 32'hFFFF_FFFF);
    chk("t6_wd_err", bus.out_err, 1);
    chk("t6_wd_correct", bus.out_correct, 0);
    chk("t6_wd_total", bus.stat_total, 1);
    bus.out_ready = 1; tick(); bus.out_ready = 0;
    net_val = 5; net_delay = TO;
    run_img(5, rand_img(), lat);
    chk("t6_edge_pred", bus.out_pred, 5);
    chk("t6_edge_correct", bus.out_correct, 1);
    chk("t6_edge_err", bus.out_err, 0);
    bus.out_ready = 1; tick(); bus.out_ready = 0;
    net_delay = 0;
    bus.in_valid = 1; tick(); bus.in_valid = 0;
    for (int i = 0; i < 5; i++) tick();
    do_reset();
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_in_ready", bus.in_ready, 1);
    chk("t6_rst_out_valid", bus.out_valid, 0);
    chk("t6_rst_pred", bus.out_pred, 0);
    chk("t6_rst_total", bus.stat_total, 0);
`endif
    // randomized traffic against the model
    do_reset();
    net_fixed = 0; stray_en = 1;
    for (int c = 0; c < 4000; c++) begin
      bus.in_valid = $urandom_range(0, 9) < 7;
      bus.in_img = rand_img();
      bus.in_label = $urandom_range(0, 7) == 0 ? CLS_W'($urandom) : CLS_W'($urandom_range(0, 12));
      bus.out_ready = $urandom_range(0, 9) < 6;
      drv_clr = $urandom_range(0, 49) == 0;
      rst = $urandom_range(0, 299) == 0;
      tick();
    end
    rst = 0; drv_clr = 0;
    drain();
    chk("min_start_gap_ge4", min_gap >= 4, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
